// File: rtl/axi_defs_pkg.sv
// Shared AXI4 constants and the read-DMA FSM state type.
// Contents:
//   AXI_BURST_INCR     - ARBURST encoding for incrementing bursts
//   AXI_RESP_*         - RRESP/BRESP codes
//   AXI_PAGE_BYTES     - 4 KB page that no burst may cross
//   AXI_CACHE_DEFAULT  - ARCACHE: bufferable + modifiable
//   AXI_PROT_DEFAULT   - ARPROT: unprivileged, secure, data
//   rd_state_e         - read DMA master FSM states
package axi_defs_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned AXI_PAGE_BYTES = 4096;

    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } rd_state_e;

endpackage

// File: rtl/axi_rd_burst_calc.sv
// Combinational burst-length calculator for the read DMA master.
// Returns min(remaining, MAX_BURST, beats left before the next 4 KB page).
// Ports:
//   i_addr_lo    - low 12 bits of the (beat-aligned) burst start address
//   i_remaining  - beats still to be requested for the command
//   o_beats      - beats for this burst (1..MAX_BURST when i_remaining != 0)
module axi_rd_burst_calc
    import axi_defs_pkg::*;
#(
    parameter int unsigned STRB_WIDTH = 4,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic [11:0] i_addr_lo,
    input  logic [15:0] i_remaining,
    output logic [8:0]  o_beats
);

    localparam int unsigned SIZE = $clog2(STRB_WIDTH);

    logic [12:0] w_page_bytes;
    logic [12:0] w_page_beats;
    logic [16:0] w_lim;
    logic [7:0]  w_unused_hi;

    // Bytes up to the page end; 4096 when sitting exactly on a page start.
    assign w_page_bytes = 13'(AXI_PAGE_BYTES) - {1'b0, i_addr_lo};
    assign w_page_beats = w_page_bytes >> SIZE;

    always_comb begin
        w_lim = {1'b0, i_remaining};
        if ({4'b0, w_page_beats} < w_lim) begin
            w_lim = {4'b0, w_page_beats};
        end
        if (17'(MAX_BURST) < w_lim) begin
            w_lim = 17'(MAX_BURST);
        end
    end

    // MAX_BURST <= 256 bounds the result to 9 bits.
    assign o_beats     = w_lim[8:0];
    assign w_unused_hi = w_lim[16:9];

endmodule

// File: rtl/axi_rd_dma_master.sv
// AXI4 read DMA master: splits a (address, beat count) command into INCR
// bursts that never cross a 4 KB page, keeps one burst outstanding, and
// forwards read data to a valid/ready stream with zero latency.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   cmd_valid/ready/addr/beats - command handshake (beats 0 means 1)
//   m_axi_ar*                 - AXI read address channel
//   m_axi_r*                  - AXI read data channel
//   out_data/last/valid/ready - output stream; out_last marks the final beat
//   done, err                 - completion pulse and accumulated error flag
module axi_rd_dma_master
    import axi_defs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,

    output logic                  done,
    output logic                  err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SIZE       = $clog2(STRB_WIDTH);

    rd_state_e             r_state;
    logic                  r_cmd_ready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_remaining;
    logic [8:0]            r_burst_len;
    logic [8:0]            r_beat_cnt;
    logic                  r_arvalid;
    logic                  r_done;
    logic                  r_err;

    logic [8:0]            w_beats;
    logic [8:0]            w_arlen_full;
    logic [ADDR_WIDTH-1:0] w_burst_bytes;
    logic [ADDR_WIDTH-1:0] w_cmd_addr_aligned;
    logic [15:0]           w_cmd_beats;
    logic                  w_in_data;
    logic                  w_xfer;
    logic                  w_burst_end;
    logic                  w_beat_err;
    logic                  w_unused;

    axi_rd_burst_calc #(
        .STRB_WIDTH (STRB_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .i_addr_lo   (r_addr[11:0]),
        .i_remaining (r_remaining),
        .o_beats     (w_beats)
    );

    assign w_cmd_addr_aligned = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
    assign w_cmd_beats        = (cmd_beats == 16'd0) ? 16'd1 : cmd_beats;
    assign w_burst_bytes      = ADDR_WIDTH'(w_beats) << SIZE;
    assign w_arlen_full       = w_beats - 9'd1;

    assign w_in_data   = (r_state == StData);
    assign w_xfer      = w_in_data && m_axi_rvalid && out_ready;
    // The local beat counter, not rlast, decides where a burst ends.
    assign w_burst_end = (r_beat_cnt == (r_burst_len - 9'd1));
    assign w_beat_err  = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rid != '0);
    assign w_unused    = ^{m_axi_rlast, w_arlen_full[8]};

    // araddr/arlen derive from registers that only move on the AR handshake,
    // so they stay stable while arvalid is held.
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = w_arlen_full[7:0];
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_arvalid = r_arvalid;

    assign m_axi_rready = w_in_data && out_ready;
    assign out_valid    = w_in_data && m_axi_rvalid;
    assign out_data     = m_axi_rdata;
    assign out_last     = w_in_data && m_axi_rvalid && w_burst_end && (r_remaining == 16'd0);

    assign cmd_ready = r_cmd_ready;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_burst_len <= '0;
            r_beat_cnt  <= '0;
            r_arvalid   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= w_cmd_addr_aligned;
                        r_remaining <= w_cmd_beats;
                        r_err       <= 1'b0;
                        r_arvalid   <= 1'b1;
                        r_state     <= StAddr;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                StAddr: begin
                    if (m_axi_arready) begin
                        r_arvalid   <= 1'b0;
                        r_addr      <= r_addr + w_burst_bytes;
                        r_remaining <= r_remaining - 16'(w_beats);
                        r_burst_len <= w_beats;
                        r_beat_cnt  <= '0;
                        r_state     <= StData;
                    end
                end
                StData: begin
                    if (w_xfer) begin
                        r_err <= r_err | w_beat_err;
                        if (w_burst_end) begin
                            if (r_remaining == 16'd0) begin
                                r_done      <= 1'b1;
                                r_cmd_ready <= 1'b1;
                                r_state     <= StIdle;
                            end else begin
                                r_arvalid <= 1'b1;
                                r_state   <= StAddr;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 9'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_dma_master.sv
// Self-checking bench for axi_rd_dma_master with a randomized AXI read slave
// and queue-based scoreboards for AR requests and stream beats.
module tb_axi_rd_dma_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [7:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [7:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        err;

    axi_rd_dma_master #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .ID_WIDTH   (8),
        .MAX_BURST  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done),
        .err           (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    int    n_cmp;
    int    n_mis;
    int    n_out;

    // Slave model state
    int          s_bursts[$];
    int          s_left;
    int          s_cmd_beat;
    logic [31:0] s_data;
    logic [31:0] e_data;
    int          err_resp_beat;
    int          err_id_beat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor (negedge) and AXI read slave (driven 1 time unit after posedge).
    initial begin
        logic  ar_hs;
        logic  r_hs;
        logic  out_hs;
        int    ar_len_cap;
        ar_t   ea;
        beat_t eb;
        forever begin
            @(negedge clk);
            ar_hs      = m_axi_arvalid && m_axi_arready;
            r_hs       = m_axi_rvalid && m_axi_rready;
            out_hs     = out_valid && out_ready;
            ar_len_cap = int'(m_axi_arlen) + 1;
            if (rst) begin
                if (ar_hs) begin
                    n_cmp++;
                    if (exp_ar.size() == 0) begin
                        n_mis++;
                        $display("FAIL ar_unexpected: got addr %h len %0d, required no AR",
                                 m_axi_araddr, m_axi_arlen);
                    end else begin
                        ea = exp_ar.pop_front();
                        if (m_axi_araddr !== ea.addr || m_axi_arlen !== ea.len) begin
                            n_mis++;
                            $display("FAIL ar_req: got addr %h len %0d, required addr %h len %0d",
                                     m_axi_araddr, m_axi_arlen, ea.addr, ea.len);
                        end
                    end
                    n_cmp++;
                    if ({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
                         m_axi_arprot} !== {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
                        n_mis++;
                        $display("FAIL ar_const: got id %h size %0d burst %b lock %b cache %b prot %b",
                                 m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                                 m_axi_arcache, m_axi_arprot);
                    end
                end
                if (out_hs) begin
                    n_out++;
                    n_cmp++;
                    if (exp_beat.size() == 0) begin
                        n_mis++;
                        $display("FAIL beat_unexpected: got data %h last %b, required no beat",
                                 out_data, out_last);
                    end else begin
                        eb = exp_beat.pop_front();
                        if (out_data !== eb.data || out_last !== eb.last) begin
                            n_mis++;
                            $display("FAIL beat: got data %h last %b, required data %h last %b",
                                     out_data, out_last, eb.data, eb.last);
                        end
                    end
                end
                if (out_valid) begin
                    n_cmp++;
                    if (out_data !== m_axi_rdata || !m_axi_rvalid) begin
                        n_mis++;
                        $display("FAIL passthru: got out_data %h rvalid %b, required rdata %h rvalid 1",
                                 out_data, m_axi_rvalid, m_axi_rdata);
                    end
                end
                if (!out_ready) begin
                    n_cmp++;
                    if (m_axi_rready !== 1'b0) begin
                        n_mis++;
                        $display("FAIL rready_bp: got rready %b, required 0", m_axi_rready);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                s_bursts.delete();
                s_left        = 0;
                m_axi_rvalid  = 1'b0;
                m_axi_arready = 1'b0;
                m_axi_rlast   = 1'b0;
            end else begin
                if (ar_hs) s_bursts.push_back(ar_len_cap);
                if (r_hs) begin
                    s_left--;
                    s_cmd_beat++;
                    s_data++;
                    m_axi_rvalid = 1'b0;
                end
                if (s_left == 0 && s_bursts.size() > 0) s_left = s_bursts.pop_front();
                m_axi_arready = ($urandom_range(0, 3) != 0);
                if (!m_axi_rvalid && s_left > 0 && $urandom_range(0, 3) != 0) m_axi_rvalid = 1'b1;
            end
            m_axi_rdata = s_data;
            m_axi_rlast = m_axi_rvalid && (s_left == 1);
            m_axi_rresp = (s_cmd_beat == err_resp_beat) ? 2'b10 : 2'b00;
            m_axi_rid   = (s_cmd_beat == err_id_beat) ? 8'h05 : 8'h00;
        end
    end

    task automatic push_ar(input logic [31:0] addr, input logic [7:0] len);
        ar_t a;
        a.addr = addr;
        a.len  = len;
        exp_ar.push_back(a);
    endtask

    task automatic push_beats(input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = e_data;
            b.last = (k == n - 1);
            exp_beat.push_back(b);
            e_data++;
        end
    endtask

    // Reference split: min(remaining, 16, beats to next 4 KB page).
    task automatic push_model(input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int rem;
        int pg;
        int b;
        a   = addr & 32'hFFFF_FFFC;
        rem = (beats == 0) ? 1 : beats;
        push_beats(rem);
        while (rem > 0) begin
            pg = (4096 - int'(a[11:0])) / 4;
            b  = rem;
            if (b > 16) b = 16;
            if (b > pg) b = pg;
            push_ar(a, 8'(b - 1));
            a   = a + 32'(b * 4);
            rem = rem - b;
        end
    endtask

    task automatic issue_cmd(input logic [31:0] addr, input logic [15:0] beats, output bit ok);
        ok = 1'b0;
        @(posedge clk);
        #1;
        s_cmd_beat = 0;
        cmd_valid  = 1'b1;
        cmd_addr   = addr;
        cmd_beats  = beats;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output logic e);
        ok = 1'b0;
        e  = 1'bx;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                e  = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, m_axi_arvalid, m_axi_rready, out_valid, out_last, done, err} !== 7'b0) begin
            n_mis++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {cmd_ready, m_axi_arvalid, m_axi_rready, out_valid, out_last, done, err});
        end
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_release_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic e;
        push_ar(32'h4000_0000, 8'd3);
        push_beats(4);
        issue_cmd(32'h4000_0000, 16'd4, ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL single_accept: got no cmd_ready, required accept"); end
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0) begin
            n_mis++;
            $display("FAIL single_done: got done %b err %b, required done 1 err 0", ok, e);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL single_idle_ready: got %b, required 1", cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_mis++; $display("FAIL done_pulse: got %b, required 0", done); end
        n_cmp++;
        if (exp_ar.size() != 0 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL single_left: got %0d ARs %0d beats pending, required 0",
                     exp_ar.size(), exp_beat.size());
        end
    endtask

    task automatic test_multi_burst();
        bit ok;
        logic e;
        push_ar(32'h4000_0000, 8'd15);
        push_ar(32'h4000_0040, 8'd15);
        push_ar(32'h4000_0080, 8'd7);
        push_beats(40);
        issue_cmd(32'h4000_0000, 16'd40, ok);
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0) begin
            n_mis++;
            $display("FAIL multi_done: got done %b err %b, required done 1 err 0", ok, e);
        end
        n_cmp++;
        if (exp_ar.size() != 0 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL multi_left: got %0d ARs %0d beats pending, required 0",
                     exp_ar.size(), exp_beat.size());
        end
    endtask

    task automatic test_page_cross();
        bit ok;
        logic e;
        push_ar(32'h4000_0FF8, 8'd1);
        push_ar(32'h4000_1000, 8'd1);
        push_beats(4);
        issue_cmd(32'h4000_0FF8, 16'd4, ok);
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0) begin
            n_mis++;
            $display("FAIL page_done: got done %b err %b, required done 1 err 0", ok, e);
        end
        n_cmp++;
        if (exp_ar.size() != 0 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL page_left: got %0d ARs %0d beats pending, required 0",
                     exp_ar.size(), exp_beat.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic e;
        int n0;
        s_data = 32'd1;
        e_data = 32'd1;
        push_ar(32'h4000_0000, 8'd7);
        push_beats(8);
        n0 = n_out;
        issue_cmd(32'h4000_0000, 16'd8, ok);
        for (int i = 0; i < 500 && n_out < n0 + 3; i++) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0) begin
            n_mis++;
            $display("FAIL bp_done: got done %b err %b, required done 1 err 0", ok, e);
        end
        n_cmp++;
        if (n_out - n0 != 8 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL bp_count: got %0d beats, required 8", n_out - n0);
        end
    endtask

    task automatic test_err_resp();
        bit ok;
        logic e;
        err_resp_beat = 1;
        push_ar(32'h4000_0100, 8'd3);
        push_beats(4);
        issue_cmd(32'h4000_0100, 16'd4, ok);
        wait_done(ok, e);
        err_resp_beat = -1;
        n_cmp++;
        if (!ok || e !== 1'b1) begin
            n_mis++;
            $display("FAIL err_resp: got done %b err %b, required done 1 err 1", ok, e);
        end
        n_cmp++;
        if (exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL err_resp_fwd: got %0d beats missing, required 0", exp_beat.size());
        end
    endtask

    // rid error in the first burst must still be reported after the second.
    task automatic test_err_id_and_clear();
        bit ok;
        logic e;
        err_id_beat = 2;
        push_model(32'h4000_0200, 20);
        issue_cmd(32'h4000_0200, 16'd20, ok);
        wait_done(ok, e);
        err_id_beat = -1;
        n_cmp++;
        if (!ok || e !== 1'b1) begin
            n_mis++;
            $display("FAIL err_id: got done %b err %b, required done 1 err 1", ok, e);
        end
        push_model(32'h4000_0300, 3);
        issue_cmd(32'h4000_0300, 16'd3, ok);
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0) begin
            n_mis++;
            $display("FAIL err_clear: got done %b err %b, required done 1 err 0", ok, e);
        end
    endtask

    task automatic test_zero_unaligned();
        bit ok;
        logic e;
        push_ar(32'h4000_0000, 8'd0);
        push_beats(1);
        issue_cmd(32'h4000_0003, 16'd0, ok);
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0 || exp_ar.size() != 0 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL zero_beats: got done %b err %b pending %0d/%0d, required 1 0 0/0",
                     ok, e, exp_ar.size(), exp_beat.size());
        end
    endtask

    task automatic test_model_mix();
        bit ok;
        logic e;
        push_model(32'h4000_0F00, 100);
        issue_cmd(32'h4000_0F00, 16'd100, ok);
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0 || exp_ar.size() != 0 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL model_a: got done %b err %b pending %0d/%0d, required 1 0 0/0",
                     ok, e, exp_ar.size(), exp_beat.size());
        end
        push_model(32'h1234_5FC4, 33);
        issue_cmd(32'h1234_5FC4, 16'd33, ok);
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0 || exp_ar.size() != 0 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL model_b: got done %b err %b pending %0d/%0d, required 1 0 0/0",
                     ok, e, exp_ar.size(), exp_beat.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic e;
        push_model(32'h4000_2000, 5);
        push_model(32'h4000_3FFC, 3);
        issue_cmd(32'h4000_2000, 16'd5, ok);
        wait_done(ok, e);
        issue_cmd(32'h4000_3FFC, 16'd3, ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL b2b_accept: got no cmd_ready, required accept"); end
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0 || exp_ar.size() != 0 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL b2b_done: got done %b err %b pending %0d/%0d, required 1 0 0/0",
                     ok, e, exp_ar.size(), exp_beat.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic e;
        int n0;
        push_model(32'h4000_5000, 8);
        n0 = n_out;
        issue_cmd(32'h4000_5000, 16'd8, ok);
        for (int i = 0; i < 500 && n_out < n0 + 2; i++) @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({m_axi_arvalid, m_axi_rready, out_valid, cmd_ready, done, err} !== 6'b0) begin
            n_mis++;
            $display("FAIL reset_mid: got arvalid/rready/out_valid/cmd_ready/done/err %b, required 000000",
                     {m_axi_arvalid, m_axi_rready, out_valid, cmd_ready, done, err});
        end
        exp_ar.delete();
        exp_beat.delete();
        s_data = 32'h0000_0100;
        e_data = 32'h0000_0100;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        push_model(32'h4000_6000, 5);
        issue_cmd(32'h4000_6000, 16'd5, ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL reset_mid_accept: got no cmd_ready, required accept"); end
        wait_done(ok, e);
        n_cmp++;
        if (!ok || e !== 1'b0 || exp_ar.size() != 0 || exp_beat.size() != 0) begin
            n_mis++;
            $display("FAIL reset_mid_after: got done %b err %b pending %0d/%0d, required 1 0 0/0",
                     ok, e, exp_ar.size(), exp_beat.size());
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_mis         = 0;
        n_out         = 0;
        s_left        = 0;
        s_cmd_beat    = 0;
        s_data        = 32'hA000_0000;
        e_data        = 32'hA000_0000;
        err_resp_beat = -1;
        err_id_beat   = -1;
        rst           = 1'b0;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_beats     = '0;
        out_ready     = 1'b1;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rid     = 8'h00;
        m_axi_rlast   = 1'b0;
        test_reset();
        test_single();
        test_multi_burst();
        test_page_cross();
        test_backpressure();
        test_err_resp();
        test_err_id_and_clear();
        test_zero_unaligned();
        test_model_mix();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/axi_rd_dma_master.md
AXI_RD_DMA_MASTER -- requirements
Module: axi_rd_dma_master

Interface
REQ-001 DATA_WIDTH, 32, AXI/stream data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-002 ADDR_WIDTH, 32, AXI byte-address width.
REQ-003 ID_WIDTH, 8, AXI ID width; ARID is constant 0.
REQ-004 MAX_BURST, 16, max beats per AR burst (1..256).
REQ-005 One clock; reset is asynchronous and active-low. Ports clk and rst follow that convention.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 cmd_valid  in  1  command valid.
REQ-009 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-010 cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits treated as 0.
REQ-011 cmd_beats  in  16  total beats; 0 is treated as 1.
REQ-012 m_axi_arid  out  ID_WIDTH  constant 0.
REQ-013 m_axi_araddr  out  ADDR_WIDTH  burst start address.
REQ-014 m_axi_arlen  out  8  beats-1.
REQ-015 m_axi_arsize  out  3  constant log2(STRB_WIDTH).
REQ-016 m_axi_arburst  out  2  constant INCR (01).
REQ-017 m_axi_arlock  out  1  constant 0.
REQ-018 m_axi_arcache  out  4  constant 0011.
REQ-019 m_axi_arprot  out  3  constant 000.
REQ-020 m_axi_arvalid  out  1  AR valid.
REQ-021 m_axi_arready  in  1  AR ready.
REQ-022 m_axi_rid  in  ID_WIDTH  read ID.
REQ-023 m_axi_rdata  in  DATA_WIDTH  read data.
REQ-024 m_axi_rresp  in  2  read response.
REQ-025 m_axi_rlast  in  1  last beat of burst.
REQ-026 m_axi_rvalid  in  1  R valid.
REQ-027 m_axi_rready  out  1  R ready.
REQ-028 out_data  out  DATA_WIDTH  stream data.
REQ-029 out_last  out  1  final beat of the whole command.
REQ-030 out_valid  out  1  stream valid.
REQ-031 out_ready  in  1  stream ready.
REQ-032 done  out  1  one-cycle pulse after final beat transfers.
REQ-033 err  out  1  valid with done; 1 if any beat had rresp!=00 or rid!=0.

Function
REQ-034 FSM states IDLE, ADDR, DATA; cmd_ready=1 only in IDLE; accepted command -> ADDR next cycle, latching address and remaining count.
REQ-035 Burst beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/STRB_WIDTH); a burst never crosses a 4 KB boundary.
REQ-036 ADDR: arvalid=1 with stable araddr/arlen until arready; on handshake -> DATA, with addr += beats*STRB_WIDTH and remaining -= beats.
REQ-037 One burst outstanding; the next AR issues only after the rlast beat is transferred.
REQ-038 DATA: zero-latency pass-through, with out_valid=rvalid, rready=out_ready, and out_data=rdata; no beat is dropped or reordered under backpressure.
REQ-039 rlast beat with remaining==0 -> out_last=1 on that beat, done pulse and err valid next cycle, return to IDLE; otherwise -> ADDR.
REQ-040 err accumulates across all bursts of a command, clears on command accept, and beats are still forwarded on error.
REQ-041 Early or missing rlast relative to arlen is not checked; the beat counter is authoritative for out_last.

Reset
REQ-042 rst low -> immediately IDLE; cmd_ready=0 during reset and 1 after release; arvalid, rready, out_valid, out_last, done, err, counters = 0; a reset mid-burst abandons the command.

Structure
REQ-043 AXI constants (INCR, RESP codes, 4 KB page size, cache/prot defaults) live in shared package axi_defs_pkg.
REQ-044 Burst-length computation is sub-module axi_rd_burst_calc (combinational: addr, remaining -> beats).

Verification
REQ-045 With DATA_WIDTH=32, addr 0x4000_0000, beats 4 -> one AR with arlen=3 and arsize=2; 4 stream beats, out_last on the 4th, done, err=0.
REQ-046 Beats 40 at 0x4000_0000 -> ARs at 0x4000_0000/0x4000_0040/0x4000_0080 with arlen 15/15/7.
REQ-047 Addr 0x4000_0FF8, beats 4 -> AR 0x4000_0FF8 arlen=1, then AR 0x4000_1000 arlen=1.
REQ-048 out_ready low for 3 cycles mid-burst -> rready low for those cycles; the data sequence 1..8 arrives intact.
REQ-049 rresp=10 on beat 2 of 4 -> all 4 beats forwarded; err=1 with done.
REQ-050 rst low during DATA -> arvalid, rready, and out_valid 0 immediately; a new command after release completes normally.
